// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle RV32 main controller FSM
// Sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory with a MemReady handshake.
module multicycle_control_fsm #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic [6:0]       Opcode,
   input  logic             Zero,
   input  logic             MemReady,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             Branch,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemToReg,
   output logic             ALUSrc,
   output logic             RegWrite,
   output logic [1:0]       ALUOp,
   output logic             Exit,
   output logic             Error,
   output logic [2:0]       State,
   output logic [CNT_W-1:0] InstrCount
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      K_NONE, K_R, K_I, K_LOAD, K_STORE, K_BRANCH
   } klass_t;

   state_t            state_q, state_d;
   klass_t            klass_q, klass_dec;
   logic [WAIT_W-1:0] wait_q;
   logic [CNT_W-1:0]  count_q;
   logic              error_q;
   logic              timeout, retire, set_error;

   // Plain case matching never hits a legal item with X/Z bits, so those fall to K_NONE.
   always_comb begin
      klass_dec = K_NONE;
      case (Opcode)
         7'b0110011: klass_dec = K_R;
         7'b0010011: klass_dec = K_I;
         7'b0000011: klass_dec = K_LOAD;
         7'b0100011: klass_dec = K_STORE;
         7'b1100011: klass_dec = K_BRANCH;
         default:    klass_dec = K_NONE;
      endcase
   end

   assign timeout = (MEM_TIMEOUT != 0) && !MemReady && (wait_q == WAIT_LAST);

   always_comb begin
      state_d   = state_q;
      set_error = 1'b0;
      retire    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      Branch    = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      MemToReg  = 1'b0;
      ALUSrc    = 1'b0;
      RegWrite  = 1'b0;
      ALUOp     = 2'b00;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            if (MemReady) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = S_DECODE;
            end else if (timeout) begin
               state_d   = S_HALT;
               set_error = 1'b1;
            end
         end
         S_DECODE: state_d = (klass_dec == K_NONE) ? S_HALT : S_EXEC;
         S_EXEC: begin
            case (klass_q)
               K_R: begin
                  ALUOp   = 2'b10;
                  state_d = S_WB;
               end
               K_I: begin
                  ALUSrc  = 1'b1;
                  ALUOp   = 2'b11;
                  state_d = S_WB;
               end
               K_LOAD, K_STORE: begin
                  ALUSrc  = 1'b1;
                  state_d = S_MEM;
               end
               K_BRANCH: begin
                  ALUOp   = 2'b01;
                  Branch  = 1'b1;
                  PCWrite = Zero;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               default: begin
                  state_d   = S_HALT;
                  set_error = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            if (klass_q == K_LOAD || klass_q == K_STORE) begin
               MemRead  = (klass_q == K_LOAD);
               MemWrite = (klass_q == K_STORE);
               if (MemReady) begin
                  retire  = (klass_q == K_STORE);
                  state_d = (klass_q == K_LOAD) ? S_WB : S_FETCH;
               end else if (timeout) begin
                  state_d   = S_HALT;
                  set_error = 1'b1;
               end
            end else begin
               state_d   = S_HALT;
               set_error = 1'b1;
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            MemToReg = (klass_q == K_LOAD);
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
         default: begin
            state_d   = S_HALT;
            set_error = 1'b1;
         end
      endcase
      // Reset drops any in-flight request at once, without waiting for the state register.
      if (!Reset_n) begin
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         Branch   = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         MemToReg = 1'b0;
         ALUSrc   = 1'b0;
         RegWrite = 1'b0;
         ALUOp    = 2'b00;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_FETCH;
         klass_q <= K_NONE;
         wait_q  <= '0;
         count_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) klass_q <= klass_dec;
         if (state_d != state_q) wait_q <= '0;
         else if (!MemReady && (state_q == S_FETCH || state_q == S_MEM)) wait_q <= wait_q + WAIT_W'(1);
         if (retire) count_q <= count_q + CNT_W'(1);
         if (set_error) error_q <= 1'b1;
      end
   end

   assign Exit       = (state_q == S_HALT);
   assign Error      = error_q;
   assign State      = state_q;
   assign InstrCount = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

   logic        Clock = 1'b0;
   logic        Reset_n = 1'b0;
   logic [6:0]  Opcode = 7'd0;
   logic        Zero = 1'b0;
   logic        MemReady = 1'b0;
   logic        IRWrite, PCWrite, Branch, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite;
   logic [1:0]  ALUOp;
   logic        Exit, Error;
   logic [2:0]  State;
   logic [31:0] InstrCount;
   logic [11:0] sig;

   localparam logic [11:0] L_IRW  = 12'h800;
   localparam logic [11:0] L_PCW  = 12'h400;
   localparam logic [11:0] L_BRN  = 12'h200;
   localparam logic [11:0] L_MRD  = 12'h100;
   localparam logic [11:0] L_MWR  = 12'h080;
   localparam logic [11:0] L_M2R  = 12'h040;
   localparam logic [11:0] L_ASRC = 12'h020;
   localparam logic [11:0] L_RGW  = 12'h010;
   localparam logic [11:0] L_OPBR = 12'h004;
   localparam logic [11:0] L_OPR  = 12'h008;
   localparam logic [11:0] L_OPI  = 12'h00C;
   localparam logic [11:0] L_EXIT = 12'h002;
   localparam logic [11:0] L_ERR  = 12'h001;
   localparam logic [11:0] L_FOK  = L_IRW | L_PCW | L_MRD;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   typedef struct {
      logic [6:0]  op;
      logic        z;
      logic        mr;
      logic [2:0]  st;
      logic [11:0] sig;
      logic [31:0] cnt;
   } cyc_t;

   cyc_t sb[$];
   int   checks = 0;
   int   failures = 0;

   multicycle_control_fsm #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .MemRead(MemRead),
      .MemWrite(MemWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
      .ALUOp(ALUOp), .Exit(Exit), .Error(Error), .State(State), .InstrCount(InstrCount)
   );

   assign sig = {IRWrite, PCWrite, Branch, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite,
                 ALUOp, Exit, Error};

   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      Reset_n = 1'b0;
      MemReady = 1'b0;
      Opcode = 7'd0;
      Zero = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      Reset_n = 1'b1;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      MemReady = 1'b1;
      Opcode = OP_R;
      @(negedge Clock);
      #1;
      checks++;
      if ({State, sig, InstrCount} !== {3'd0, 12'h000, 32'd0}) begin
         failures++;
         $display("FAIL reset state=%0d sig=%h cnt=%0d expected state=0 sig=000 cnt=0", State, sig, InstrCount);
      end
   endtask

   task automatic test_r_type();
      cyc_t c;
      int n = 0;
      apply_reset();
      sb.push_back('{7'd0, 1'b0, 1'b1, 3'd0, L_FOK,  32'd0});
      sb.push_back('{OP_R, 1'b0, 1'b0, 3'd1, 12'h000, 32'd0});
      sb.push_back('{OP_I, 1'b1, 1'b0, 3'd2, L_OPR,  32'd0});
      sb.push_back('{7'd0, 1'b0, 1'b0, 3'd4, L_RGW,  32'd0});
      sb.push_back('{7'd0, 1'b0, 1'b0, 3'd0, L_MRD,  32'd1});
      sb.push_back('{7'd0, 1'b0, 1'b1, 3'd0, L_FOK,  32'd1});
      sb.push_back('{OP_I, 1'b0, 1'b0, 3'd1, 12'h000, 32'd1});
      sb.push_back('{7'd0, 1'b0, 1'b0, 3'd2, L_ASRC | L_OPI, 32'd1});
      sb.push_back('{7'd0, 1'b0, 1'b0, 3'd4, L_RGW,  32'd1});
      sb.push_back('{7'd0, 1'b0, 1'b0, 3'd0, L_MRD,  32'd2});
      while (sb.size() != 0) begin
         c = sb.pop_front();
         Opcode = c.op; Zero = c.z; MemReady = c.mr;
         #1;
         checks++;
         if ({State, sig, InstrCount} !== {c.st, c.sig, c.cnt}) begin
            failures++;
            $display("FAIL r_type cyc%0d state=%0d sig=%h cnt=%0d expected state=%0d sig=%h cnt=%0d",
                     n, State, sig, InstrCount, c.st, c.sig, c.cnt);
         end
         n++;
         @(negedge Clock);
      end
   endtask

   task automatic test_load_wait();
      cyc_t c;
      int n = 0;
      apply_reset();
      sb.push_back('{7'd0,  1'b0, 1'b1, 3'd0, L_FOK,  32'd0});
      sb.push_back('{OP_LD, 1'b0, 1'b0, 3'd1, 12'h000, 32'd0});
      sb.push_back('{7'd0,  1'b0, 1'b0, 3'd2, L_ASRC, 32'd0});
      for (int i = 0; i < 3; i++) sb.push_back('{7'd0, 1'b0, 1'b0, 3'd3, L_MRD, 32'd0});
      sb.push_back('{7'd0,  1'b0, 1'b1, 3'd3, L_MRD,  32'd0});
      sb.push_back('{7'd0,  1'b0, 1'b0, 3'd4, L_RGW | L_M2R, 32'd0});
      sb.push_back('{7'd0,  1'b0, 1'b0, 3'd0, L_MRD,  32'd1});
      while (sb.size() != 0) begin
         c = sb.pop_front();
         Opcode = c.op; Zero = c.z; MemReady = c.mr;
         #1;
         checks++;
         if ({State, sig, InstrCount} !== {c.st, c.sig, c.cnt}) begin
            failures++;
            $display("FAIL load_wait cyc%0d state=%0d sig=%h cnt=%0d expected state=%0d sig=%h cnt=%0d",
                     n, State, sig, InstrCount, c.st, c.sig, c.cnt);
         end
         n++;
         @(negedge Clock);
      end
   endtask

   task automatic test_back_to_back_branch();
      cyc_t c;
      int n = 0;
      apply_reset();
      sb.push_back('{7'd0,  1'b0, 1'b1, 3'd0, L_FOK, 32'd0});
      sb.push_back('{OP_BR, 1'b0, 1'b0, 3'd1, 12'h000, 32'd0});
      sb.push_back('{7'd0,  1'b1, 1'b0, 3'd2, L_BRN | L_PCW | L_OPBR, 32'd0});
      sb.push_back('{7'd0,  1'b0, 1'b1, 3'd0, L_FOK, 32'd1});
      sb.push_back('{OP_BR, 1'b1, 1'b0, 3'd1, 12'h000, 32'd1});
      sb.push_back('{7'd0,  1'b0, 1'b0, 3'd2, L_BRN | L_OPBR, 32'd1});
      sb.push_back('{7'd0,  1'b0, 1'b0, 3'd0, L_MRD, 32'd2});
      while (sb.size() != 0) begin
         c = sb.pop_front();
         Opcode = c.op; Zero = c.z; MemReady = c.mr;
         #1;
         checks++;
         if ({State, sig, InstrCount} !== {c.st, c.sig, c.cnt}) begin
            failures++;
            $display("FAIL branch cyc%0d state=%0d sig=%h cnt=%0d expected state=%0d sig=%h cnt=%0d",
                     n, State, sig, InstrCount, c.st, c.sig, c.cnt);
         end
         n++;
         @(negedge Clock);
      end
   endtask

   task automatic test_illegal_opcode();
      cyc_t c;
      int n = 0;
      for (int pass = 0; pass < 2; pass++) begin
         apply_reset();
         sb.push_back('{7'd0, 1'b0, 1'b1, 3'd0, L_FOK, 32'd0});
         if (pass == 0) sb.push_back('{7'b1111111, 1'b0, 1'b0, 3'd1, 12'h000, 32'd0});
         else           sb.push_back('{7'bxxxxxxx, 1'b0, 1'b0, 3'd1, 12'h000, 32'd0});
         for (int i = 0; i < 20; i++)
            sb.push_back('{7'($urandom_range(0, 127)), i[0], ~i[0], 3'd5, L_EXIT, 32'd0});
         while (sb.size() != 0) begin
            c = sb.pop_front();
            Opcode = c.op; Zero = c.z; MemReady = c.mr;
            #1;
            checks++;
            if ({State, sig, InstrCount} !== {c.st, c.sig, c.cnt}) begin
               failures++;
               $display("FAIL illegal_op pass%0d cyc%0d state=%0d sig=%h cnt=%0d expected state=%0d sig=%h cnt=%0d",
                        pass, n, State, sig, InstrCount, c.st, c.sig, c.cnt);
            end
            n++;
            @(negedge Clock);
         end
      end
   endtask

   task automatic test_timeout();
      cyc_t c;
      int n = 0;
      for (int pass = 0; pass < 2; pass++) begin
         apply_reset();
         for (int i = 0; i < 7; i++) sb.push_back('{7'd0, 1'b0, 1'b0, 3'd0, L_MRD, 32'd0});
         if (pass == 0) begin
            sb.push_back('{7'd0, 1'b0, 1'b0, 3'd0, L_MRD, 32'd0});
            for (int i = 0; i < 4; i++)
               sb.push_back('{OP_R, i[0], ~i[0], 3'd5, L_EXIT | L_ERR, 32'd0});
         end else begin
            sb.push_back('{7'd0, 1'b0, 1'b1, 3'd0, L_FOK, 32'd0});
            sb.push_back('{OP_R, 1'b0, 1'b0, 3'd1, 12'h000, 32'd0});
            sb.push_back('{7'd0, 1'b0, 1'b0, 3'd2, L_OPR, 32'd0});
         end
         while (sb.size() != 0) begin
            c = sb.pop_front();
            Opcode = c.op; Zero = c.z; MemReady = c.mr;
            #1;
            checks++;
            if ({State, sig, InstrCount} !== {c.st, c.sig, c.cnt}) begin
               failures++;
               $display("FAIL timeout pass%0d cyc%0d state=%0d sig=%h cnt=%0d expected state=%0d sig=%h cnt=%0d",
                        pass, n, State, sig, InstrCount, c.st, c.sig, c.cnt);
            end
            n++;
            @(negedge Clock);
         end
      end
   endtask

   task automatic test_store_reset();
      cyc_t c;
      int n = 0;
      apply_reset();
      sb.push_back('{7'd0,  1'b0, 1'b1, 3'd0, L_FOK,  32'd0});
      sb.push_back('{OP_ST, 1'b0, 1'b0, 3'd1, 12'h000, 32'd0});
      sb.push_back('{7'd0,  1'b0, 1'b0, 3'd2, L_ASRC, 32'd0});
      sb.push_back('{7'd0,  1'b0, 1'b0, 3'd3, L_MWR,  32'd0});
      sb.push_back('{7'd0,  1'b0, 1'b1, 3'd3, L_MWR,  32'd0});
      sb.push_back('{7'd0,  1'b0, 1'b1, 3'd0, L_FOK,  32'd1});
      sb.push_back('{OP_ST, 1'b0, 1'b0, 3'd1, 12'h000, 32'd1});
      sb.push_back('{7'd0,  1'b0, 1'b0, 3'd2, L_ASRC, 32'd1});
      sb.push_back('{7'd0,  1'b0, 1'b0, 3'd3, L_MWR,  32'd1});
      while (sb.size() != 0) begin
         c = sb.pop_front();
         Opcode = c.op; Zero = c.z; MemReady = c.mr;
         #1;
         checks++;
         if ({State, sig, InstrCount} !== {c.st, c.sig, c.cnt}) begin
            failures++;
            $display("FAIL store cyc%0d state=%0d sig=%h cnt=%0d expected state=%0d sig=%h cnt=%0d",
                     n, State, sig, InstrCount, c.st, c.sig, c.cnt);
         end
         n++;
         @(negedge Clock);
      end
      #1;
      checks++;
      if ({State, MemWrite} !== {3'd3, 1'b1}) begin
         failures++;
         $display("FAIL store_mid_mem state=%0d MemWrite=%b expected state=3 MemWrite=1", State, MemWrite);
      end
      #2 Reset_n = 1'b0;
      #1;
      checks++;
      if ({State, sig, InstrCount} !== {3'd0, 12'h000, 32'd0}) begin
         failures++;
         $display("FAIL store_async_reset state=%0d sig=%h cnt=%0d expected state=0 sig=000 cnt=0",
                  State, sig, InstrCount);
      end
      @(negedge Clock);
      Reset_n = 1'b1;
      #1;
      checks++;
      if ({State, Exit, Error, InstrCount} !== {3'd0, 1'b0, 1'b0, 32'd0}) begin
         failures++;
         $display("FAIL store_after_release state=%0d Exit=%b Error=%b cnt=%0d expected state=0 Exit=0 Error=0 cnt=0",
                  State, Exit, Error, InstrCount);
      end
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_load_wait();
      test_back_to_back_branch();
      test_illegal_opcode();
      test_timeout();
      test_store_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
